// File: rtl/sap1_datapath.sv
// SAP-1 datapath: W-bus, PC/MAR/IR/A/B/OUT registers, 16x8 RAM and add/sub ALU.
// Consumes the 12-bit controller word and returns the opcode for sequencing.
module sap1_datapath #(
  parameter int          WIDTH   = 8,
  parameter int          ADDR    = 4,
  parameter logic [11:0] IDLE_CW = 12'h3E3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [11:0]      cntrl_bus,
  input  logic             prog_we,
  input  logic [ADDR-1:0]  prog_addr,
  input  logic [WIDTH-1:0] prog_data,
  output logic [3:0]       opcode,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] w_bus,
  output logic             carry,
  output logic             halt,
  output logic             bus_conflict
);

  localparam int DEPTH = 2 ** ADDR;

  // XOR with the idle word turns every control line active-high.
  logic [11:0] act;
  assign act = cntrl_bus ^ IDLE_CW;

  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  assign cp = act[11];
  assign ep = act[10];
  assign lm = act[9];
  assign ce = act[8];
  assign li = act[7];
  assign ei = act[6];
  assign la = act[5];
  assign ea = act[4];
  assign su = act[3];
  assign eu = act[2];
  assign lb = act[1];
  assign lo = act[0];

  logic [ADDR-1:0]  pc;
  logic [ADDR-1:0]  mar;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;

  logic [WIDTH-1:0] ram [DEPTH];
  logic [WIDTH-1:0] ram_rd;
  assign ram_rd = ram[mar];

  always_ff @(posedge clk) begin
    if (prog_we) ram[prog_addr] <= prog_data;
  end

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  assign b_op = su ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, b_op} + (WIDTH+1)'(su);

  logic [WIDTH-1:0] pc_ext;
  logic [WIDTH-1:0] ir_ext;
  assign pc_ext = {{(WIDTH-ADDR){1'b0}}, pc};
  assign ir_ext = {{(WIDTH-ADDR){1'b0}}, ir[ADDR-1:0]};

  always_comb begin
    w_bus = '0;
    if (ep)      w_bus = pc_ext;
    else if (ce) w_bus = ram_rd;
    else if (ei) w_bus = ir_ext;
    else if (ea) w_bus = a;
    else if (eu) w_bus = sum[WIDTH-1:0];
  end

  logic [4:0] drv;
  assign drv          = {ep, ce, ei, ea, eu};
  assign bus_conflict = |(drv & (drv - 5'd1));

  always_ff @(posedge clk) begin
    if (clr) begin
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (cp) pc <= pc + ADDR'(1);
      if (lm) mar <= w_bus[ADDR-1:0];
      if (li) ir <= w_bus;
      if (la) a <= w_bus;
      if (lb) b <= w_bus;
      if (lo) out_q <= w_bus;
      if (eu && la) carry_q <= sum[WIDTH];
    end
  end

  assign opcode   = ir[WIDTH-1 -: 4];
  assign halt     = (opcode == 4'hF);
  assign out_port = out_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath: register setup via RAM,
// table-driven ALU and bus-resolution vectors, plus corner sequences.
module tb_sap1_datapath;

  localparam logic [11:0] IDLE = 12'h3E3;

  logic        clk = 1'b0;
  logic        clr;
  logic [11:0] cntrl_bus;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  out_port;
  logic [7:0]  w_bus;
  logic        carry;
  logic        halt;
  logic        bus_conflict;

  sap1_datapath dut (
    .clk          (clk),
    .clr          (clr),
    .cntrl_bus    (cntrl_bus),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .opcode       (opcode),
    .out_port     (out_port),
    .w_bus        (w_bus),
    .carry        (carry),
    .halt         (halt),
    .bus_conflict (bus_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       su;
    logic [7:0] res;
    logic       cy;
  } alu_vec_t;

  typedef struct {
    logic [11:0] cw;
    logic [7:0]  bus;
    logic        conf;
  } bus_vec_t;

  alu_vec_t alu_tab [8];
  bus_vec_t bus_tab [12];

  int errors = 0;
  int checks = 0;
  logic [3:0] mar_m;
  logic [3:0] pc_m;
  logic [7:0] pv;
  logic       pc_c;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [11:0] cw);
    @(negedge clk);
    cntrl_bus = cw;
    @(posedge clk);
    #1;
    cntrl_bus = IDLE;
  endtask

  task automatic do_clr(input logic [11:0] cw);
    @(negedge clk);
    clr = 1'b1;
    cntrl_bus = cw;
    @(posedge clk);
    #1;
    clr = 1'b0;
    cntrl_bus = IDLE;
    mar_m = 4'h0;
    pc_m  = 4'h0;
  endtask

  task automatic pwr(input logic [3:0] ad, input logic [7:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = ad;
    prog_data = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic peek(input logic [11:0] cw, output logic [7:0] v,
                      output logic c);
    @(negedge clk);
    cntrl_bus = cw;
    #1;
    v = w_bus;
    c = bus_conflict;
    cntrl_bus = IDLE;
  endtask

  task automatic set_a(input logic [7:0] v);
    pwr(mar_m, v);
    cyc(12'h2C3);
  endtask

  task automatic set_b(input logic [7:0] v);
    pwr(mar_m, v);
    cyc(12'h2E1);
  endtask

  task automatic set_ir(input logic [7:0] v);
    pwr(mar_m, v);
    cyc(12'h263);
  endtask

  task automatic set_mar(input logic [3:0] ad);
    pwr(mar_m, {4'h0, ad});
    cyc(12'h0E3);
    mar_m = ad;
  endtask

  task automatic set_pc(input logic [3:0] p);
    for (int i = 0; i < 16 && pc_m != p; i++) begin
      cyc(12'hBE3);
      pc_m = pc_m + 4'd1;
    end
  endtask

  initial begin
    alu_tab[0] = '{8'h10, 8'h14, 1'b0, 8'h24, 1'b0};
    alu_tab[1] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0};
    alu_tab[2] = '{8'h30, 8'h20, 1'b1, 8'h10, 1'b1};
    alu_tab[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    alu_tab[4] = '{8'h20, 8'h20, 1'b1, 8'h00, 1'b1};
    alu_tab[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0};
    alu_tab[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    alu_tab[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    bus_tab[0]  = '{12'h3E3, 8'h00, 1'b0};
    bus_tab[1]  = '{12'h7F3, 8'h05, 1'b1};
    bus_tab[2]  = '{12'h3F3, 8'h77, 1'b0};
    bus_tab[3]  = '{12'h7E3, 8'h05, 1'b0};
    bus_tab[4]  = '{12'h2E3, 8'h99, 1'b0};
    bus_tab[5]  = '{12'h3A3, 8'h0C, 1'b0};
    bus_tab[6]  = '{12'h3E7, 8'h88, 1'b0};
    bus_tab[7]  = '{12'h3EF, 8'h66, 1'b0};
    bus_tab[8]  = '{12'h2A3, 8'h99, 1'b1};
    bus_tab[9]  = '{12'h3B3, 8'h0C, 1'b1};
    bus_tab[10] = '{12'h3F7, 8'h77, 1'b1};
    bus_tab[11] = '{12'h6E3, 8'h05, 1'b1};

    clr       = 1'b1;
    cntrl_bus = IDLE;
    prog_we   = 1'b0;
    prog_addr = 4'h0;
    prog_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    clr   = 1'b0;
    mar_m = 4'h0;
    pc_m  = 4'h0;

    // Reset: dirty every register, then clear with a loading word.
    set_mar(4'h6);
    set_a(8'h55);
    set_b(8'h11);
    set_ir(8'hF7);
    set_pc(4'h3);
    cyc(12'h3F2);
    pwr(4'h0, 8'h3C);
    check("pre_out", out_port, 8'h55);
    check("pre_halt", {7'b0, halt}, 8'h01);
    do_clr(12'h1A3);
    peek(12'h7E3, pv, pc_c);
    check("rst_pc", pv, 8'h00);
    peek(12'h3F3, pv, pc_c);
    check("rst_a", pv, 8'h00);
    peek(12'h3A3, pv, pc_c);
    check("rst_ir", pv, 8'h00);
    peek(12'h2E3, pv, pc_c);
    check("rst_mar_ram", pv, 8'h3C);
    peek(12'h3E7, pv, pc_c);
    check("rst_b", pv, 8'h00);
    check("rst_out", out_port, 8'h00);
    check("rst_opcode", {4'h0, opcode}, 8'h00);
    check("rst_halt", {7'b0, halt}, 8'h00);
    check("rst_carry", {7'b0, carry}, 8'h00);

    // LDA fetch/execute.
    pwr(4'h0, 8'h09);
    pwr(4'h9, 8'h10);
    cyc(12'h5E3);
    cyc(12'hBE3);
    cyc(12'h263);
    check("lda_opcode", {4'h0, opcode}, 8'h00);
    cyc(12'h1A3);
    cyc(12'h2C3);
    cyc(12'h3E3);
    pc_m  = 4'h1;
    mar_m = 4'h9;
    peek(12'h7E3, pv, pc_c);
    check("lda_pc", pv, 8'h01);
    peek(12'h3A3, pv, pc_c);
    check("lda_ir", pv, 8'h09);
    peek(12'h2E3, pv, pc_c);
    check("lda_mar", pv, 8'h10);
    peek(12'h3F3, pv, pc_c);
    check("lda_a", pv, 8'h10);

    // ADD with carry via IR-addressed operand.
    set_ir(8'h0A);
    set_a(8'hF0);
    pwr(4'hA, 8'h20);
    cyc(12'h1A3);
    mar_m = 4'hA;
    cyc(12'h2E1);
    cyc(12'h3C7);
    peek(12'h3F3, pv, pc_c);
    check("add_cy_a", pv, 8'h10);
    check("add_cy_c", {7'b0, carry}, 8'h01);

    for (int i = 0; i < 8; i++) begin
      set_a(alu_tab[i].a);
      set_b(alu_tab[i].b);
      cyc(alu_tab[i].su ? 12'h3CF : 12'h3C7);
      peek(12'h3F3, pv, pc_c);
      check($sformatf("alu%0d_res", i), pv, alu_tab[i].res);
      check($sformatf("alu%0d_cy", i), {7'b0, carry}, {7'b0, alu_tab[i].cy});
    end

    // Carry holds without an A load; Ea with La keeps A.
    set_a(8'hFF);
    set_b(8'h01);
    cyc(12'h3E7);
    check("cy_hold", {7'b0, carry}, 8'h00);
    cyc(12'h3D3);
    peek(12'h3F3, pv, pc_c);
    check("ea_la_a", pv, 8'hFF);

    // OUT and HLT.
    set_ir(8'hE0);
    set_a(8'h24);
    cyc(12'h3F2);
    check("out_port", out_port, 8'h24);
    check("out_opcode", {4'h0, opcode}, 8'h0E);
    check("out_halt", {7'b0, halt}, 8'h00);
    set_ir(8'hF0);
    check("hlt_halt", {7'b0, halt}, 8'h01);
    check("hlt_opcode", {4'h0, opcode}, 8'h0F);

    // PC wrap after 16 increments.
    do_clr(IDLE);
    repeat (15) cyc(12'hBE3);
    peek(12'h7E3, pv, pc_c);
    check("pc_15", pv, 8'h0F);
    cyc(12'hBE3);
    peek(12'h7E3, pv, pc_c);
    check("pc_wrap", pv, 8'h00);

    // Cp with Ep: MAR gets old PC, PC increments.
    pwr(4'h0, 8'h6B);
    cyc(12'hDE3);
    pc_m  = 4'h1;
    mar_m = 4'h0;
    peek(12'h7E3, pv, pc_c);
    check("cpep_pc", pv, 8'h01);
    peek(12'h2E3, pv, pc_c);
    check("cpep_mar", pv, 8'h6B);

    // Bus resolution and conflicts.
    set_mar(4'h3);
    set_ir(8'h4C);
    set_b(8'h11);
    set_a(8'h77);
    pwr(4'h3, 8'h99);
    set_pc(4'h5);
    for (int i = 0; i < 12; i++) begin
      peek(bus_tab[i].cw, pv, pc_c);
      check($sformatf("bus%0d_val", i), pv, bus_tab[i].bus);
      check($sformatf("bus%0d_conf", i), {7'b0, pc_c}, {7'b0, bus_tab[i].conf});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
